// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, requester-id width and
// response slot state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_LUI = 4'b0100;

    localparam int unsigned REQ_ID_W = 1;

    typedef enum logic {
        SlotEmpty = 1'b0,
        SlotFull  = 1'b1
    } slot_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU: ADD/SUB/OR/LUI plus zero flag. Unknown opcodes give 0.
module alu_arbiter_alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  zero_o
);

    // Opcode decode and result select.
    always_comb begin
        data_o = '0;
        unique case (op_i)
            ALU_ADD: data_o = a_i + b_i;
            ALU_SUB: data_o = a_i - b_i;
            ALU_OR:  data_o = a_i | b_i;
            ALU_LUI: data_o = {b_i[15:0], {(DATA_WIDTH - 16){1'b0}}};
            default: data_o = '0;
        endcase
        zero_o = (data_o == '0);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared ALU, with a single registered
// response slot. Define ALU_ARB_ROUND_ROBIN_EN for round-robin priority;
// otherwise requester 0 always wins ties.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_REQ      = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    input  logic [3:0]            req0_op_i,
    input  logic [DATA_WIDTH-1:0] req0_a_i,
    input  logic [DATA_WIDTH-1:0] req0_b_i,
    output logic                  req0_ready_o,
    input  logic                  req1_valid_i,
    input  logic [3:0]            req1_op_i,
    input  logic [DATA_WIDTH-1:0] req1_a_i,
    input  logic [DATA_WIDTH-1:0] req1_b_i,
    output logic                  req1_ready_o,
    output logic                  rsp_valid_o,
    output logic [REQ_ID_W-1:0]   rsp_id_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_zero_o,
    input  logic                  rsp_ready_i
);

    slot_e                  slot_q, slot_d;
    logic [REQ_ID_W-1:0]    last_gnt_q, last_gnt_d;
    logic [REQ_ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic                   rsp_zero_q, rsp_zero_d;

    logic                   slot_free;
    logic                   pick1;
    logic                   gnt0, gnt1, transfer;
    logic [$clog2(N_REQ)-1:0] gnt_id;
    logic [3:0]             alu_op;
    logic [DATA_WIDTH-1:0]  alu_a, alu_b, alu_data;
    logic                   alu_zero;

    // Grant decision; ready is forced low while reset is held.
    always_comb begin
        slot_free = (slot_q == SlotEmpty) || rsp_ready_i;
        pick1     = 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        if (req0_valid_i && req1_valid_i) begin
            pick1 = (last_gnt_q == 1'b0);
        end else begin
            pick1 = req1_valid_i;
        end
`else
        pick1 = !req0_valid_i && req1_valid_i;
`endif
        gnt0     = reset && slot_free && req0_valid_i && !pick1;
        gnt1     = reset && slot_free && req1_valid_i && pick1;
        transfer = gnt0 || gnt1;
        gnt_id   = gnt1;
    end

    // Operand mux into the shared ALU.
    always_comb begin
        alu_op = gnt1 ? req1_op_i : req0_op_i;
        alu_a  = gnt1 ? req1_a_i  : req0_a_i;
        alu_b  = gnt1 ? req1_b_i  : req0_b_i;
    end

    alu_arbiter_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op_i   (alu_op),
        .a_i    (alu_a),
        .b_i    (alu_b),
        .data_o (alu_data),
        .zero_o (alu_zero)
    );

    // Slot next state: load on transfer, empty on drain, otherwise hold.
    always_comb begin
        slot_d     = slot_q;
        last_gnt_d = last_gnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_zero_d = rsp_zero_q;
        if (transfer) begin
            slot_d     = SlotFull;
            last_gnt_d = gnt_id;
            rsp_id_d   = gnt_id;
            rsp_data_d = alu_data;
            rsp_zero_d = alu_zero;
        end else if (slot_q == SlotFull && rsp_ready_i) begin
            slot_d = SlotEmpty;
        end
    end

    // State registers; reset drops the held response immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_q     <= SlotEmpty;
            last_gnt_q <= 1'b1;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            last_gnt_q <= last_gnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign req0_ready_o = gnt0;
    assign req1_ready_o = gnt1;
    assign rsp_valid_o  = (slot_q == SlotFull);
    assign rsp_id_o     = rsp_id_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_zero_o   = rsp_zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_zero;
    logic        rsp_ready;

    int n_run  = 0;
    int n_fail = 0;

    // Model of the response slot and the priority memory.
    bit          m_full;
    bit          m_id;
    logic [31:0] m_data;
    bit          m_zero;
    bit          m_last;

    typedef struct {
        bit          id;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
        bit          exp_zero;
    } vec_t;

    vec_t vecs[6];

    alu_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid_i (req0_valid),
        .req0_op_i    (req0_op),
        .req0_a_i     (req0_a),
        .req0_b_i     (req0_b),
        .req0_ready_o (req0_ready),
        .req1_valid_i (req1_valid),
        .req1_op_i    (req1_op),
        .req1_a_i     (req1_a),
        .req1_b_i     (req1_b),
        .req1_ready_o (req1_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_id_o     (rsp_id),
        .rsp_data_o   (rsp_data),
        .rsp_zero_o   (rsp_zero),
        .rsp_ready_i  (rsp_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            4'b0011: return a + b;
            4'b0001: return a - b;
            4'b0010: return a | b;
            4'b0100: return b << 16;
            default: return 32'd0;
        endcase
    endfunction

    // -1: nobody, else the requester that should win this cycle.
    function automatic int winner(input bit v0, input bit v1);
        if (!v0 && !v1) return -1;
        if (v0 && !v1) return 0;
        if (v1 && !v0) return 1;
`ifdef ALU_ARB_ROUND_ROBIN_EN
        return (m_last == 1'b0) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 1'b0;
        m_data = 32'd0;
        m_zero = 1'b0;
        m_last = 1'b1;
    endtask

    task automatic model_load(input bit id, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        m_full = 1'b1;
        m_id   = id;
        m_last = id;
        m_data = ref_result(op, a, b);
        m_zero = (m_data == 32'd0);
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
        req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    endtask

    task automatic drive(input bit which, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        if (which == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // One clock: check readies, advance model on the edge, check the slot.
    task automatic tick();
        bit free;
        int w;
        #1;
        free = !m_full || rsp_ready;
        w    = free ? winner(req0_valid, req1_valid) : -1;
        chk("ready0", {31'd0, req0_ready}, {31'd0, (w == 0)});
        chk("ready1", {31'd0, req1_ready}, {31'd0, (w == 1)});
        @(posedge clk);
        if (w == 0) model_load(1'b0, req0_op, req0_a, req0_b);
        else if (w == 1) model_load(1'b1, req1_op, req1_a, req1_b);
        else if (m_full && rsp_ready) m_full = 1'b0;
        #1;
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_full});
        chk("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
    endtask

    initial begin
        logic [3:0] ops[5];
        int         exp_g[4];

        vecs[0] = '{1'b1, 4'b0100, 32'h0,        32'h0000_ABCD, 32'hABCD_0000, 1'b0};
        vecs[1] = '{1'b1, 4'b0010, 32'hF0,       32'h0F,        32'hFF,        1'b0};
        vecs[2] = '{1'b0, 4'b1111, 32'h5,        32'h6,         32'h0,         1'b1};
        vecs[3] = '{1'b0, 4'b0011, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1};
        vecs[4] = '{1'b1, 4'b0001, 32'h3,        32'h5,         32'hFFFF_FFFE, 1'b0};
        vecs[5] = '{1'b0, 4'b0001, 32'h9,        32'h9,         32'h0,         1'b1};

        // Reset with requests present: no grants, cleared slot.
        reset      = 1'b0;
        rsp_ready  = 1'b1;
        idle_inputs();
        drive(1'b0, 4'b0011, 32'd1, 32'd1);
        drive(1'b1, 4'b0011, 32'd2, 32'd2);
        model_reset();
        #3;
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, req1_ready}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_zero", {31'd0, rsp_zero}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;

        // Single ADD from requester 0.
        drive(1'b0, 4'b0011, 32'd5, 32'd7);
        tick();
        chk("add_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_id", {31'd0, rsp_id}, 32'd0);
        chk("add_data", rsp_data, 32'd12);
        chk("add_zero", {31'd0, rsp_zero}, 32'd0);

        // Directed vector table, one request at a time, drained every cycle.
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            drive(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            chk("vec_valid", {31'd0, rsp_valid}, 32'd1);
            chk("vec_id", {31'd0, rsp_id}, {31'd0, vecs[i].id});
            chk("vec_data", rsp_data, vecs[i].exp_data);
            chk("vec_zero", {31'd0, rsp_zero}, {31'd0, vecs[i].exp_zero});
        end

        // Backpressure: held slot blocks both requesters for three cycles.
        idle_inputs();
        drive(1'b0, 4'b0011, 32'd1, 32'd2);
        tick();
        rsp_ready = 1'b0;
        drive(1'b0, 4'b0011, 32'd10, 32'd10);
        drive(1'b1, 4'b0010, 32'h100, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_data, 32'd3);
            chk("bp_id", {31'd0, rsp_id}, 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release", {31'd0, (req0_ready | req1_ready)}, 32'd1);
        tick();

        // Randomized traffic against the model.
        ops[0] = 4'b0011; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0100;
        for (int i = 0; i < 400; i++) begin
            ops[4]     = 4'($urandom);
            req0_valid = 1'($urandom);
            req0_op    = ops[$urandom_range(4)];
            req0_a     = ($urandom_range(3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req0_b     = ($urandom_range(3) == 0) ? req0_a : $urandom;
            req1_valid = 1'($urandom);
            req1_op    = ops[$urandom_range(4)];
            req1_a     = $urandom;
            req1_b     = ($urandom_range(3) == 0) ? req1_a : $urandom;
            rsp_ready  = ($urandom_range(3) != 0);
            tick();
        end

        // Asynchronous reset while a response is held.
        idle_inputs();
        rsp_ready = 1'b1;
        drive(1'b1, 4'b0010, 32'd1, 32'd2);
        tick();
        idle_inputs();
        rsp_ready = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("arst_data", rsp_data, 32'd0);
        rsp_ready = 1'b1;
        drive(1'b0, 4'b0001, 32'd9, 32'd9);
        drive(1'b1, 4'b0001, 32'd9, 32'd9);
        #1;
        chk("arst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("arst_ready1", {31'd0, req1_ready}, 32'd0);
        model_reset();
        reset = 1'b1;

        // Ties after reset: SUB 9-9 from both, drained every cycle.
`ifdef ALU_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("tie_ready0", {31'd0, req0_ready}, {31'd0, (exp_g[i] == 0)});
            chk("tie_ready1", {31'd0, req1_ready}, {31'd0, (exp_g[i] == 1)});
            tick();
            chk("tie_id", {31'd0, rsp_id}, exp_g[i]);
            chk("tie_data", rsp_data, 32'd0);
            chk("tie_zero", {31'd0, rsp_zero}, 32'd1);
        end

        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational 32-bit ALU (opcodes ADD/SUB/OR/LUI, zero flag) between two requesters, e.g. the main execute stage and an address-generation unit. It arbitrates per cycle and drives the granted request's operation and operands into the ALU instance. It captures data and zero into a single registered response slot tagged with the requester id, and holds it until the consumer accepts it. Throughput is one operation per cycle when the response is drained every cycle.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width; only 32 is supported.
- N_REQ, 2, requester count; fixed, no other value supported.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req0_valid_i  input  1  requester 0 has an operation.
- req0_op_i  input  4  requester 0 ALU operation.
- req0_a_i, req0_b_i  input  32 each  requester 0 operands.
- req0_ready_o  output  1  requester 0 granted this cycle.
- req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_ready_o  same as requester 0, for requester 1.
- rsp_valid_o  output  1  response slot holds a result.
- rsp_id_o  output  1  requester that owns the result.
- rsp_data_o  output  32  registered ALU result.
- rsp_zero_o  output  1  registered zero flag.
- rsp_ready_i  input  1  consumer accepts the response.

## Operation
- Opcodes: ADD=4'b0011 gives a+b mod 2^32. SUB=4'b0001 gives a−b mod 2^32. OR=4'b0010 gives a|b. LUI=4'b0100 gives {b[15:0],16'h0}.
- Any other opcode gives data 0 and zero=1. It is not an error.
- zero = (data == 0).
- Slot state is one bit: EMPTY or FULL.
- slot_free = EMPTY, or FULL with rsp_ready_i=1 (drain and refill in the same cycle).
- A grant is issued only when slot_free is true and at least one valid is high. At most one reqN_ready_o is high per cycle.
- A request transfers on the clock edge where valid and ready are both high.
- reqN_ready_o is combinational from the valids, slot state, rsp_ready_i and the priority pointer. It never depends on reqN_valid_i of the same requester for its own grant decision beyond the request being present.
- Priority is round-robin, see Configuration. The pointer last_gnt updates only on a transfer.
- Transitions:
  - EMPTY + transfer → FULL, load data, zero and id.
  - FULL + rsp_ready_i, no transfer → EMPTY.
  - FULL + rsp_ready_i + transfer → FULL with new contents.
  - FULL + !rsp_ready_i → hold all outputs stable.
- A requester may drop valid without a grant. No ordering promise is made across requesters.

## Timing
- Latency: a transfer at edge k gives rsp_valid_o=1 after edge k.
- Sustained rate is 1 op/cycle with rsp_ready_i held at 1.
- Reset values: rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_zero_o=0, last_gnt=1, slot=EMPTY.
- During reset both ready outputs are 0.
- Reset asserted mid-operation discards the held response immediately and asynchronously. There is no pending grant after release.
- Simultaneous valids with last_gnt=1: requester 0 is granted.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined: round-robin. The requester not equal to last_gnt wins ties.
- ALU_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins. last_gnt is still maintained but ignored.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams ALU_ADD, ALU_SUB, ALU_OR, ALU_LUI;
  - the requester-id width constant;
  - the slot state encoding.
- One sub-module: the existing ALU, instantiated once, fed by the grant mux. Its data and zero outputs feed the response register.
- The grant mux and the state register stay in this module.

## Test plan
- Reset release, req0 ADD a=5 b=7 → ready0=1 same cycle; next cycle rsp_valid=1, id=0, data=12, zero=0.
- Both valid, both SUB a=9 b=9, rsp_ready=1 held:
  - with ALU_ARB_ROUND_ROBIN_EN, grants alternate 0,1,0,1;
  - without it, req0 is always granted and ready1 stays 0;
  - every response has data=0, zero=1.
- Backpressure: response held with rsp_ready=0 → ready0=ready1=0, outputs stable for 3 cycles. Raising rsp_ready admits the next request in the same cycle.
- req1 LUI b=32'h0000_ABCD → data=32'hABCD_0000, id=1. req1 OR a=32'hF0 b=32'h0F → data=32'hFF.
- Undefined op 4'b1111 → data=0, zero=1. ADD a=32'hFFFF_FFFF b=1 → data=0, zero=1 (wrap-around).
- reset asserted while FULL with rsp_ready=0 → rsp_valid_o drops to 0 without waiting for a clock edge. After release, the first tie grants requester 0.
